// File: rtl/busio_pkg.sv
// Shared types and constants for the fetch/data bus arbiter.
package busio_pkg;

  localparam int unsigned ADDR_W             = 32;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned STRB_W             = 4;
  localparam int unsigned FAIR_LIMIT_DEFAULT = 4;

  // Arbiter FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Current bus transaction owner
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_MEM   = 1'b1
  } owner_e;

endpackage

// File: rtl/busio_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one external bus
// with a single outstanding transaction (IDLE -> REQ -> RESP).
// Optional feature macro: BUSIO_FAIRNESS_EN bounds how many data grants may
// bypass a waiting fetch; without it the data port has strict priority.
module busio_arbiter
  import busio_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT = FAIR_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_address,
  input  logic              fetch_abort,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic [STRB_W-1:0] mem_byte_enable,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              mem_ready,
  output logic              ext_valid,
  input  logic              ext_ready,
  output logic [ADDR_W-1:0] ext_address,
  output logic              ext_write,
  output logic [DATA_W-1:0] ext_write_data,
  output logic [STRB_W-1:0] ext_strobe,
  input  logic              ext_rvalid,
  input  logic [DATA_W-1:0] ext_rdata
);

  // Reject out-of-range limits at elaboration
  if ((FAIR_LIMIT < 1) || (FAIR_LIMIT > 15)) begin : g_bad_limit
    $error("busio_arbiter: FAIR_LIMIT must be in 1..15");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  owner_e              r_owner;
  logic                r_discard;
  logic                r_ext_valid;
  logic [ADDR_W-1:0]   r_ext_address;
  logic                r_ext_write;
  logic [DATA_W-1:0]   r_ext_write_data;
  logic [STRB_W-1:0]   r_ext_strobe;
  logic                w_grant_fetch;
  logic                w_grant_mem;
  logic                w_fair_hit;
  logic                w_abort_hit;
  logic                w_discard;
  logic                w_resp_done;

`ifdef BUSIO_FAIRNESS_EN
  localparam int unsigned CNT_W = 4;
  logic [CNT_W-1:0] r_fair_cnt;

  assign w_fair_hit = (r_fair_cnt == CNT_W'(FAIR_LIMIT));

  // Count data grants that bypassed a waiting fetch; a fetch grant resets it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fair_cnt <= '0;
    end else if (w_grant_fetch) begin
      r_fair_cnt <= '0;
    end else if (w_grant_mem && fetch_valid && !w_fair_hit) begin
      r_fair_cnt <= r_fair_cnt + CNT_W'(1);
    end
  end
`else
  assign w_fair_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and grant decode; data wins ties unless fetch has waited too long
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_fetch = 1'b0;
    w_grant_mem   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid && !(fetch_valid && w_fair_hit)) begin
          w_grant_mem = 1'b1;
          w_state_nxt = ST_REQ;
        end else if (fetch_valid) begin
          w_grant_fetch = 1'b1;
          w_state_nxt   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ext_ready) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (ext_rvalid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A redirect only matters while a fetch owns the bus
  assign w_abort_hit = fetch_abort && (r_owner == OWN_FETCH) &&
                       ((r_state == ST_REQ) || (r_state == ST_RESP));
  assign w_discard   = r_discard || w_abort_hit;
  assign w_resp_done = (r_state == ST_RESP) && ext_rvalid;

  // Latch the granted request and hold it stable on the bus until accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner          <= OWN_FETCH;
      r_discard        <= 1'b0;
      r_ext_valid      <= 1'b0;
      r_ext_address    <= '0;
      r_ext_write      <= 1'b0;
      r_ext_write_data <= '0;
      r_ext_strobe     <= '0;
    end else begin
      r_ext_valid <= (w_state_nxt == ST_REQ);
      if (w_grant_mem) begin
        r_owner          <= OWN_MEM;
        r_ext_address    <= mem_address;
        r_ext_write      <= mem_write;
        r_ext_write_data <= mem_write_data;
        r_ext_strobe     <= mem_byte_enable;
      end else if (w_grant_fetch) begin
        r_owner          <= OWN_FETCH;
        r_ext_address    <= fetch_address;
        r_ext_write      <= 1'b0;
        r_ext_write_data <= '0;
        r_ext_strobe     <= {STRB_W{1'b1}};
      end
      if (w_state_nxt == ST_IDLE) begin
        r_discard <= 1'b0;
      end else if (w_abort_hit) begin
        r_discard <= 1'b1;
      end
    end
  end

  assign ext_valid      = r_ext_valid;
  assign ext_address    = r_ext_address;
  assign ext_write      = r_ext_write;
  assign ext_write_data = r_ext_write_data;
  assign ext_strobe     = r_ext_strobe;

  // Completion pulses follow the bus response in the same cycle
  assign fetch_ready   = w_resp_done && (r_owner == OWN_FETCH) && !w_discard;
  assign fetch_data    = ext_rdata;
  assign mem_ready     = !mem_valid || (w_resp_done && (r_owner == OWN_MEM));
  assign mem_read_data = ext_rdata;

endmodule

// File: tb/tb_busio_arbiter.sv
// Scoreboard bench for busio_arbiter: directed requests, a simple bus slave,
// and a negedge monitor that checks bus fields and completion pulses.
module tb_busio_arbiter;

  logic        clk;
  logic        reset_n;
  logic        fetch_valid;
  logic [31:0] fetch_address;
  logic        fetch_abort;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        mem_valid;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        ext_valid;
  logic        ext_ready;
  logic [31:0] ext_address;
  logic        ext_write;
  logic [31:0] ext_write_data;
  logic [3:0]  ext_strobe;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;

  busio_arbiter #(.FAIR_LIMIT(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_address(fetch_address),
    .fetch_abort(fetch_abort), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .mem_valid(mem_valid), .mem_address(mem_address), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_byte_enable(mem_byte_enable),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_address(ext_address),
    .ext_write(ext_write), .ext_write_data(ext_write_data), .ext_strobe(ext_strobe),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata)
  );

  typedef struct {
    logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb;
    logic [31:0] rdata; logic is_fetch;
  } breq_t;
  typedef struct { logic is_fetch; logic [31:0] data; int lat; } rsp_t;
  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] be; } mop_t;

  breq_t       exp_req[$];
  rsp_t        exp_rsp[$];
  logic [31:0] fetch_ops[$];
  mop_t        mem_ops[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int f_issue = 0;
  int n_fpulse = 0;
  bit in_resp = 0, cur_fetch = 0, disc_model = 0, f_act = 0, m_act = 0;
  int slv_stall = 0, slv_rsp_dly = 0;
  bit slv_hold = 0;
  logic [31:0] slv_rdata = '0;
  bit abort_tgl = 0, late_tgl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] rd, input logic f);
    breq_t e;
    e.addr = a; e.wr = w; e.wdata = d; e.strb = s; e.rdata = rd; e.is_fetch = f;
    exp_req.push_back(e);
  endtask

  task automatic exp_done(input logic f, input logic [31:0] d, input int lat);
    rsp_t r;
    r.is_fetch = f; r.data = d; r.lat = lat;
    exp_rsp.push_back(r);
  endtask

  task automatic mem_op(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] be);
    mop_t m;
    m.addr = a; m.wr = w; m.wdata = d; m.be = be;
    mem_ops.push_back(m);
  endtask

  task automatic wait_idle(input string name);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done && n < 2000) begin
      @(negedge clk); #1;
      done = (fetch_ops.size() == 0) && (mem_ops.size() == 0) && !f_act && !m_act &&
             (exp_rsp.size() == 0) && (exp_req.size() == 0) && !in_resp && !ext_valid;
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus slave: accepts after slv_stall REQ cycles, responds slv_rsp_dly cycles later
  initial begin : slave
    int  req_wait;
    int  rsp_wait;
    bit  late_seen;
    ext_ready = 1'b0; ext_rvalid = 1'b0; ext_rdata = '0;
    req_wait = 0; rsp_wait = 0; late_seen = 0;
    forever begin
      @(posedge clk); #1;
      ext_rvalid = 1'b0;
      if (!reset_n) begin
        ext_ready = 1'b0; req_wait = 0; rsp_wait = 0;
      end else begin
        if (ext_valid) begin
          ext_ready = (req_wait >= slv_stall);
          req_wait++;
        end else begin
          ext_ready = 1'b0;
          req_wait = 0;
        end
        if (late_tgl != late_seen) begin
          late_seen  = late_tgl;
          ext_rvalid = 1'b1;
          ext_rdata  = 32'hBAD0_0001;
        end else if (in_resp && !slv_hold) begin
          if (rsp_wait >= slv_rsp_dly) begin
            ext_rvalid = 1'b1;
            ext_rdata  = slv_rdata;
            rsp_wait   = 0;
          end else begin
            rsp_wait++;
          end
        end else begin
          rsp_wait = 0;
        end
      end
    end
  end

  // Requester + monitor: checks outputs at negedge, retires and presents requests
  initial begin : host
    rsp_t r;
    breq_t e;
    bit exp_f, exp_m, req_f, abort_seen;
    logic [31:0] fa;
    mop_t m;
    fetch_valid = 0; fetch_address = 0; fetch_abort = 0;
    mem_valid = 0; mem_address = 0; mem_write = 0; mem_write_data = 0; mem_byte_enable = 0;
    abort_seen = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        fetch_valid = 0; mem_valid = 0; fetch_abort = 0;
        f_act = 0; m_act = 0; in_resp = 0; disc_model = 0;
        abort_seen = abort_tgl;
      end else begin
        exp_f = in_resp && cur_fetch && ext_rvalid && !disc_model;
        exp_m = !mem_valid || (in_resp && !cur_fetch && ext_rvalid);
        req_f = ext_valid && (exp_req.size() > 0) && exp_req[0].is_fetch;
        chk("fetch_ready", 32'(fetch_ready), 32'(exp_f));
        if (mem_valid) chk("mem_ready", 32'(mem_ready), 32'(exp_m));
        if (fetch_ready) begin
          n_fpulse++;
          if (exp_rsp.size() == 0) chk("spurious_fetch_ready", 32'd1, 32'd0);
          else begin
            r = exp_rsp.pop_front();
            chk("done_is_fetch", 32'd1, 32'(r.is_fetch));
            chk("fetch_data", fetch_data, r.data);
            if (r.lat >= 0) chk("fetch_latency", 32'(cyc - f_issue), 32'(r.lat));
          end
        end
        if (mem_valid && mem_ready) begin
          if (exp_rsp.size() == 0) chk("spurious_mem_ready", 32'd1, 32'd0);
          else begin
            r = exp_rsp.pop_front();
            chk("done_is_fetch", 32'd0, 32'(r.is_fetch));
            chk("mem_read_data", mem_read_data, r.data);
          end
        end
        if (in_resp && ext_rvalid) begin
          in_resp = 0;
          disc_model = 0;
        end
        if (fetch_ready) begin f_act = 0; fetch_valid = 0; end
        if (mem_valid && mem_ready) begin m_act = 0; mem_valid = 0; end
        if (ext_valid) begin
          if (exp_req.size() == 0) chk("spurious_ext_valid", 32'd1, 32'd0);
          else begin
            e = exp_req[0];
            chk("ext_address", ext_address, e.addr);
            chk("ext_write", 32'(ext_write), 32'(e.wr));
            chk("ext_strobe", 32'(ext_strobe), 32'(e.strb));
            if (e.wr) chk("ext_write_data", ext_write_data, e.wdata);
            if (ext_ready) begin
              slv_rdata = e.rdata;
              cur_fetch = e.is_fetch;
              in_resp   = 1;
              void'(exp_req.pop_front());
            end
          end
        end
        fetch_abort = 0;
        if (abort_tgl != abort_seen) begin
          abort_seen  = abort_tgl;
          fetch_abort = 1;
          if ((in_resp && cur_fetch) || req_f) disc_model = 1;
          if (f_act) begin f_act = 0; fetch_valid = 0; end
        end
        if (!f_act && fetch_ops.size() > 0) begin
          fa = fetch_ops.pop_front();
          f_act = 1; fetch_valid = 1; fetch_address = fa; f_issue = cyc;
        end
        if (!m_act && mem_ops.size() > 0) begin
          m = mem_ops.pop_front();
          m_act = 1; mem_valid = 1; mem_address = m.addr; mem_write = m.wr;
          mem_write_data = m.wdata; mem_byte_enable = m.be;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int pulses;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ext_valid", 32'(ext_valid), 32'd0);
    chk("rst_ext_address", ext_address, 32'd0);
    chk("rst_ext_write_data", ext_write_data, 32'd0);
    chk("rst_ext_strobe", 32'(ext_strobe), 32'd0);
    chk("rst_ext_write", 32'(ext_write), 32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    @(posedge clk); #2 reset_n = 1'b1;

    // Lone fetch, minimum latency
    @(posedge clk); #2;
    slv_stall = 0; slv_rsp_dly = 0;
    exp_bus(32'h100, 0, 0, 4'hF, 32'h0000_0013, 1);
    exp_done(1, 32'h0000_0013, 2);
    fetch_ops.push_back(32'h100);
    wait_idle("t1_fetch_idle");

    // Simultaneous fetch and load: load first
    @(posedge clk); #2;
    slv_stall = 0; slv_rsp_dly = 1;
    exp_bus(32'h2000, 0, 0, 4'hF, 32'hCAFE_0001, 0);
    exp_bus(32'h104, 0, 0, 4'hF, 32'h0000_0093, 1);
    exp_done(0, 32'hCAFE_0001, -1);
    exp_done(1, 32'h0000_0093, -1);
    mem_op(32'h2000, 0, 0, 4'hF);
    fetch_ops.push_back(32'h104);
    wait_idle("t2_conflict_idle");

    // Store waits for ack
    @(posedge clk); #2;
    slv_stall = 1; slv_rsp_dly = 2;
    exp_bus(32'h40, 1, 32'hDEAD_BEEF, 4'b0011, 32'h0, 0);
    exp_done(0, 32'h0, -1);
    mem_op(32'h40, 1, 32'hDEAD_BEEF, 4'b0011);
    wait_idle("t3_store_idle");

    // Continuous loads with a waiting fetch
    @(posedge clk); #2;
    slv_stall = 0; slv_rsp_dly = 0;
`ifdef BUSIO_FAIRNESS_EN
    for (int i = 0; i < 4; i++) begin
      exp_bus(32'h3000 + 32'(4 * i), 0, 0, 4'hF, 32'h1000 + 32'(i), 0);
      exp_done(0, 32'h1000 + 32'(i), -1);
    end
    exp_bus(32'h108, 0, 0, 4'hF, 32'h0000_0073, 1);
    exp_done(1, 32'h0000_0073, -1);
    exp_bus(32'h3010, 0, 0, 4'hF, 32'h1004, 0);
    exp_done(0, 32'h1004, -1);
`else
    for (int i = 0; i < 5; i++) begin
      exp_bus(32'h3000 + 32'(4 * i), 0, 0, 4'hF, 32'h1000 + 32'(i), 0);
      exp_done(0, 32'h1000 + 32'(i), -1);
    end
    exp_bus(32'h108, 0, 0, 4'hF, 32'h0000_0073, 1);
    exp_done(1, 32'h0000_0073, -1);
`endif
    for (int i = 0; i < 5; i++) mem_op(32'h3000 + 32'(4 * i), 0, 0, 4'hF);
    fetch_ops.push_back(32'h108);
    wait_idle("t4_fair_idle");

    // Abort during a stalled REQ
    @(posedge clk); #2;
    slv_stall = 3; slv_rsp_dly = 0;
    pulses = n_fpulse;
    exp_bus(32'h200, 0, 0, 4'hF, 32'hFFFF_FFFF, 1);
    fetch_ops.push_back(32'h200);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!ext_valid && n < 50);
    chk("t5_req_seen", 32'(ext_valid), 32'd1);
    @(posedge clk); #2 abort_tgl = ~abort_tgl;
    @(negedge clk); #1;
    chk("t5_hold_valid_a", 32'(ext_valid), 32'd1);
    @(negedge clk); #1;
    chk("t5_hold_valid_b", 32'(ext_valid), 32'd1);
    wait_idle("t5_abort_idle");
    chk("t5_no_fetch_pulse", 32'(n_fpulse - pulses), 32'd0);

    // Abort in IDLE is ignored
    @(posedge clk); #2;
    slv_stall = 0; slv_rsp_dly = 0;
    exp_bus(32'h300, 0, 0, 4'hF, 32'h0000_006F, 1);
    exp_done(1, 32'h0000_006F, 2);
    fetch_ops.push_back(32'h300);
    abort_tgl = ~abort_tgl;
    wait_idle("t6_idle_abort_idle");

    // Reset during RESP, then a late response
    @(posedge clk); #2;
    slv_hold = 1;
    exp_bus(32'h400, 0, 0, 4'hF, 32'h0000_0BAD, 1);
    fetch_ops.push_back(32'h400);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!in_resp && n < 50);
    chk("t7_in_resp", 32'(in_resp), 32'd1);
    @(posedge clk); #2 reset_n = 1'b0;
    @(negedge clk); #1;
    chk("t7_rst_ext_valid", 32'(ext_valid), 32'd0);
    chk("t7_rst_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("t7_rst_ext_address", ext_address, 32'd0);
    chk("t7_rst_ext_strobe", 32'(ext_strobe), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1; slv_hold = 0;
    late_tgl = ~late_tgl;
    @(negedge clk); #1;
    chk("t7_late_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("t7_late_ext_valid", 32'(ext_valid), 32'd0);
    chk("t7_late_mem_ready", 32'(mem_ready), 32'd1);

    // Fresh fetch after the abandoned transaction
    @(posedge clk); #2;
    exp_bus(32'h500, 0, 0, 4'hF, 32'h0000_0537, 1);
    exp_done(1, 32'h0000_0537, 2);
    fetch_ops.push_back(32'h500);
    wait_idle("t8_after_reset_idle");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
